// File: rtl/game_pkg.sv
// Shared encodings for the game input conditioner: flow states, button bit
// positions and the auto-repeat counter width.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int CNT_W = 8;

endpackage

// File: rtl/game_input_ctrl_key_repeat.sv
// Press/auto-repeat counter for one resolved direction: fires on a fresh
// press, then after DELAY_FRAMES ticks, then every REPEAT_FRAMES ticks.
module key_repeat
  import game_pkg::*;
#(
  parameter int DELAY_FRAMES  = 20,
  parameter int REPEAT_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic held,
  input  logic fresh,
  input  logic tick,
  output logic fire
);

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] REPEAT_LD = CNT_W'(REPEAT_FRAMES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_cnt_nxt;

  // A zero count with a steady direction only happens on the first RUN
  // cycle, so it doubles as the "entered RUN while held" load condition.
  always_comb begin
    fire        = 1'b0;
    rpt_cnt_nxt = rpt_cnt;
    if (!en || !held) begin
      rpt_cnt_nxt = '0;
    end else if (fresh) begin
      fire        = 1'b1;
      rpt_cnt_nxt = DELAY_LD;
    end else if (rpt_cnt == '0) begin
      rpt_cnt_nxt = DELAY_LD;
    end else if (tick) begin
      if (rpt_cnt == ONE) begin
        fire        = 1'b1;
        rpt_cnt_nxt = REPEAT_LD;
      end else begin
        rpt_cnt_nxt = rpt_cnt - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Turns held MCU button/start levels into single-cycle move pulses with
// frame-paced auto-repeat, and runs the idle/run/pause/over flow FSM.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int DELAY_FRAMES  = 20,
  parameter int REPEAT_FRAMES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] mcu_btn,
  input  logic       mcu_str,
  input  logic       frame_tick,
  input  logic       game_over,
  output logic       move_l,
  output logic       move_r,
  output logic [1:0] game_state,
  output logic       state_chg
);

  logic [1:0]  btn_q;
  logic        str_q;
  logic        str_q_d;
  logic [1:0]  dir_q;
  logic [1:0]  dir;
  logic        held;
  logic        fresh;
  logic        str_rise;
  logic        run_ok;
  logic        fire;
  game_state_t state;
  game_state_t state_nxt;

  assign str_rise   = str_q & ~str_q_d;
  assign dir        = (btn_q == 2'b01 || btn_q == 2'b10) ? btn_q : 2'b00;
  assign held       = |dir;
  assign fresh      = held && (dir != dir_q);
  assign game_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (str_rise) state_nxt = RUN;
      RUN: begin
        if (game_over)     state_nxt = OVER;
        else if (str_rise) state_nxt = PAUSE;
      end
      PAUSE: if (str_rise) state_nxt = RUN;
      OVER:  if (str_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pulses are only produced when the cycle they appear in is also RUN.
  assign run_ok = (state == RUN) && (state_nxt == RUN);

  key_repeat #(
    .DELAY_FRAMES (DELAY_FRAMES),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_key_repeat (
    .clk  (CLK),
    .rst  (RST),
    .en   (run_ok),
    .held (held),
    .fresh(fresh),
    .tick (frame_tick),
    .fire (fire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_q     <= '0;
      str_q     <= 1'b0;
      str_q_d   <= 1'b0;
      dir_q     <= '0;
      move_l    <= 1'b0;
      move_r    <= 1'b0;
      state_chg <= 1'b0;
    end else begin
      btn_q     <= mcu_btn;
      str_q     <= mcu_str;
      str_q_d   <= str_q;
      dir_q     <= dir;
      move_l    <= fire & dir[BTN_L];
      move_r    <= fire & dir[BTN_R];
      state_chg <= (state_nxt != state);
    end
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against a tick-counting model.
module tb_game_input_ctrl;

  localparam int D = 3;
  localparam int R = 2;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mcu_btn = 2'b00;
  logic       mcu_str = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic       move_l;
  logic       move_r;
  logic [1:0] game_state;
  logic       state_chg;

  int total = 0;
  int bad = 0;
  bit cmp_en = 0;

  // model state
  int m_bq = 0, m_sq = 0, m_sqd = 0, m_dirp = 0, m_st = 0;
  bit m_anch = 0;
  int m_tc = 0;
  int e_ml = 0, e_mr = 0, e_st = 0, e_chg = 0;

  game_input_ctrl #(.DELAY_FRAMES(D), .REPEAT_FRAMES(R)) dut (
    .CLK       (CLK),
    .RST       (rst),
    .mcu_btn   (mcu_btn),
    .mcu_str   (mcu_str),
    .frame_tick(frame_tick),
    .game_over (game_over),
    .move_l    (move_l),
    .move_r    (move_r),
    .game_state(game_state),
    .state_chg (state_chg)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: state table plus "ticks since press" arithmetic.
  initial forever begin
    int nxt, d;
    bit rise, p;
    @(posedge CLK);
    if (rst) begin
      m_bq = 0; m_sq = 0; m_sqd = 0; m_dirp = 0; m_st = 0;
      m_anch = 0; m_tc = 0;
      e_ml = 0; e_mr = 0; e_st = 0; e_chg = 0;
    end else begin
      rise = (m_sq == 1) && (m_sqd == 0);
      nxt = m_st;
      case (m_st)
        0: if (rise) nxt = 1;
        1: if (game_over) nxt = 3; else if (rise) nxt = 2;
        2: if (rise) nxt = 1;
        default: if (rise) nxt = 0;
      endcase
      d = (m_bq == 1 || m_bq == 2) ? m_bq : 0;
      p = 0;
      if (m_st == 1 && nxt == 1 && d != 0) begin
        if (d != m_dirp) begin
          p = 1; m_anch = 1; m_tc = 0;
        end else if (!m_anch) begin
          m_anch = 1; m_tc = 0;
        end else if (frame_tick) begin
          m_tc++;
          if (m_tc == D || (m_tc > D && (m_tc - D) % R == 0)) p = 1;
        end
      end else begin
        m_anch = 0;
      end
      e_ml = (p && d == 1) ? 1 : 0;
      e_mr = (p && d == 2) ? 1 : 0;
      e_chg = (nxt != m_st) ? 1 : 0;
      e_st = nxt;
      m_sqd = m_sq; m_sq = int'(mcu_str);
      m_dirp = d; m_bq = int'(mcu_btn); m_st = nxt;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (cmp_en) begin
      check("move_l", int'(move_l), e_ml);
      check("move_r", int'(move_r), e_mr);
      check("game_state", int'(game_state), e_st);
      check("state_chg", int'(state_chg), e_chg);
      if (move_l && move_r) check("both_moves", 1, 0);
    end
  end

  // str rise; state has updated on return
  task automatic str_pulse();
    mcu_str = 1'b1; @(negedge CLK);
    mcu_str = 1'b0; @(negedge CLK);
    @(negedge CLK);
  endtask

  // one frame tick after 9 idle cycles; returns the move seen right after
  task automatic tick_once(output int ml, output int mr);
    repeat (9) @(negedge CLK);
    frame_tick = 1'b1; @(negedge CLK);
    frame_tick = 1'b0;
    ml = int'(move_l); mr = int'(move_r);
  endtask

  initial begin
    int ml, mr;
    int exp_l[5] = '{0, 0, 1, 0, 1};
    repeat (2) @(negedge CLK);
    cmp_en = 1;
    check("rst_state", int'(game_state), 0);
    check("rst_moves", int'({move_l, move_r}), 0);
    check("rst_chg", int'(state_chg), 0);
    rst = 1'b0;
    @(negedge CLK);

    // start: str held 3 cycles
    mcu_str = 1'b1; @(negedge CLK);
    check("start_n1", int'(game_state), 0);
    @(negedge CLK);
    check("start_n2", int'(game_state), 1);
    check("start_chg", int'(state_chg), 1);
    @(negedge CLK);
    check("start_chg_once", int'(state_chg), 0);
    mcu_str = 1'b0;
    repeat (3) @(negedge CLK);
    check("start_stay", int'(game_state), 1);

    // auto-repeat on left
    mcu_btn = 2'b01; @(negedge CLK);
    check("press_n1", int'(move_l), 0);
    @(negedge CLK);
    check("press_n2", int'(move_l), 1);
    @(negedge CLK);
    check("press_n3", int'(move_l), 0);
    for (int i = 0; i < 5; i++) begin
      tick_once(ml, mr);
      check("repeat_l", ml, exp_l[i]);
      check("repeat_r", mr, 0);
    end

    // both pressed, then single, then direct switch
    mcu_btn = 2'b11;
    repeat (5) @(negedge CLK);
    mcu_btn = 2'b10; @(negedge CLK); @(negedge CLK);
    check("from_both_r", int'(move_r), 1);
    mcu_btn = 2'b01; @(negedge CLK); @(negedge CLK);
    check("switch_l", int'(move_l), 1);

    // pause gating with right held
    mcu_btn = 2'b10; repeat (3) @(negedge CLK);
    str_pulse();
    check("pause_state", int'(game_state), 2);
    for (int i = 0; i < 4; i++) begin
      tick_once(ml, mr);
      check("paused_r", mr, 0);
    end
    str_pulse();
    check("resume_state", int'(game_state), 1);
    check("resume_nopulse", int'(move_r), 0);
    for (int i = 0; i < 3; i++) begin
      tick_once(ml, mr);
      check("resume_rpt", mr, (i == 2) ? 1 : 0);
    end

    // game over wins over str rise
    mcu_str = 1'b1; @(negedge CLK);
    game_over = 1'b1; mcu_str = 1'b0; @(negedge CLK);
    game_over = 1'b0; @(negedge CLK);
    check("over_prio", int'(game_state), 3);
    str_pulse();
    check("over_to_idle", int'(game_state), 0);
    game_over = 1'b1; @(negedge CLK);
    game_over = 1'b0; @(negedge CLK);
    check("go_in_idle", int'(game_state), 0);
    str_pulse(); str_pulse();
    check("to_pause", int'(game_state), 2);
    game_over = 1'b1; @(negedge CLK);
    game_over = 1'b0; @(negedge CLK);
    check("go_in_pause", int'(game_state), 2);
    str_pulse();

    // reset mid-repeat
    mcu_btn = 2'b00; @(negedge CLK);
    mcu_btn = 2'b01;
    for (int i = 0; i < 4; i++) tick_once(ml, mr);
    rst = 1'b1; @(negedge CLK);
    rst = 1'b0;
    check("mid_rst_state", int'(game_state), 0);
    check("mid_rst_moves", int'({move_l, move_r}), 0);
    for (int i = 0; i < 3; i++) begin
      tick_once(ml, mr);
      check("idle_held", ml, 0);
    end
    str_pulse();
    check("rerun_state", int'(game_state), 1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(11) == 0) mcu_btn = 2'($urandom_range(3));
      if ($urandom_range(14) == 0) mcu_str = ~mcu_str;
      frame_tick = ($urandom_range(3) == 0);
      game_over = ($urandom_range(39) == 0);
      rst = ($urandom_range(399) == 0);
      @(negedge CLK);
    end
    rst = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
